// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution: prediction queue, mispredict flush/redirect, stats
module branch_resolve_unit #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CACHE_READY,
    input  logic                  CACHE_READY_DATA,
    input  logic                  IF_VALID,
    input  logic [ADDR_WIDTH-1:0] IF_PRD_ADDR,
    input  logic                  EX_VALID,
    input  logic [ADDR_WIDTH-1:0] EX_PC_IN,
    input  logic                  EX_IS_BRANCH,
    input  logic                  EX_IS_RETURN,
    input  logic                  EX_TAKEN,
    input  logic [ADDR_WIDTH-1:0] EX_TARGET,
    output logic                  BRANCH,
    output logic                  BRANCH_TAKEN,
    output logic [ADDR_WIDTH-1:0] BRANCH_ADDR,
    output logic [ADDR_WIDTH-1:0] EX_PC,
    output logic                  RETURN,
    output logic                  PREDICTED,
    output logic                  FLUSH,
    output logic                  REDIRECT_VALID,
    output logic [ADDR_WIDTH-1:0] REDIRECT_ADDR,
    output logic                  QUEUE_FULL,
    output logic                  QUEUE_ERR,
    output logic [31:0]           BRANCH_COUNT,
    output logic [31:0]           MISPRED_COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   mem_d [DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
    logic                    branch_q, branch_d, taken_q, taken_d, ret_q, ret_d;
    logic                    predicted_q, predicted_d, redirect_valid_q, redirect_valid_d;
    logic                    queue_err_q, queue_err_d;
    logic [ADDR_WIDTH-1:0]   branch_addr_q, branch_addr_d, ex_pc_q, ex_pc_d;
    logic [ADDR_WIDTH-1:0]   redirect_addr_q, redirect_addr_d;
    logic [31:0]             branch_count_q, branch_count_d, mispred_count_q, mispred_count_d;

    logic                    advance, idle, full, push, pop, ok;
    logic [ADDR_WIDTH-1:0]   actual;

    always_comb begin
        state_d          = state_q;
        mem_d            = mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        flush_cnt_d      = flush_cnt_q;
        branch_d         = branch_q;
        taken_d          = taken_q;
        ret_d            = ret_q;
        predicted_d      = predicted_q;
        redirect_valid_d = redirect_valid_q;
        queue_err_d      = queue_err_q;
        branch_addr_d    = branch_addr_q;
        ex_pc_d          = ex_pc_q;
        redirect_addr_d  = redirect_addr_q;
        branch_count_d   = branch_count_q;
        mispred_count_d  = mispred_count_q;

        advance = CACHE_READY & CACHE_READY_DATA;
        idle    = (state_q == S_IDLE);
        full    = (count_q == CW'(DEPTH));
        pop     = idle & EX_VALID & (count_q != '0);
        // A pop frees a slot in the same cycle, so a full queue can still accept a push
        push    = idle & IF_VALID & (~full | pop);
        actual  = EX_TAKEN ? EX_TARGET : EX_PC_IN + ADDR_WIDTH'(4);
        ok      = (mem_q[rd_ptr_q] == actual);

        if (advance) begin
            branch_d         = 1'b0;
            taken_d          = 1'b0;
            ret_d            = 1'b0;
            predicted_d      = 1'b1;
            redirect_valid_d = 1'b0;

            if (idle && EX_VALID && count_q == '0) begin
                queue_err_d = 1'b1;
            end

            if (pop) begin
                branch_d       = EX_IS_BRANCH;
                taken_d        = EX_TAKEN & EX_IS_BRANCH;
                ret_d          = EX_IS_RETURN;
                predicted_d    = ok;
                branch_addr_d  = EX_TARGET;
                ex_pc_d        = EX_PC_IN;
                branch_count_d = branch_count_q + 32'(EX_IS_BRANCH);
            end

            if (pop && !ok) begin
                // Everything younger is wrong-path: drop the queue including any same-cycle push
                redirect_valid_d = 1'b1;
                redirect_addr_d  = actual;
                mispred_count_d  = mispred_count_q + 32'd1;
                wr_ptr_d         = '0;
                rd_ptr_d         = '0;
                count_d          = '0;
                state_d          = S_FLUSH;
                flush_cnt_d      = FW'(FLUSH_CYCLES - 1);
            end else begin
                if (push) begin
                    mem_d[wr_ptr_q] = IF_PRD_ADDR;
                    wr_ptr_d        = wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                count_d = count_q + CW'(push) - CW'(pop);
            end

            if (state_q == S_FLUSH) begin
                if (flush_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q          <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            flush_cnt_q      <= '0;
            branch_q         <= 1'b0;
            taken_q          <= 1'b0;
            ret_q            <= 1'b0;
            predicted_q      <= 1'b1;
            redirect_valid_q <= 1'b0;
            queue_err_q      <= 1'b0;
            branch_addr_q    <= '0;
            ex_pc_q          <= '0;
            redirect_addr_q  <= '0;
            branch_count_q   <= '0;
            mispred_count_q  <= '0;
        end else begin
            state_q          <= state_d;
            mem_q            <= mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            flush_cnt_q      <= flush_cnt_d;
            branch_q         <= branch_d;
            taken_q          <= taken_d;
            ret_q            <= ret_d;
            predicted_q      <= predicted_d;
            redirect_valid_q <= redirect_valid_d;
            queue_err_q      <= queue_err_d;
            branch_addr_q    <= branch_addr_d;
            ex_pc_q          <= ex_pc_d;
            redirect_addr_q  <= redirect_addr_d;
            branch_count_q   <= branch_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign BRANCH         = branch_q;
    assign BRANCH_TAKEN   = taken_q;
    assign BRANCH_ADDR    = branch_addr_q;
    assign EX_PC          = ex_pc_q;
    assign RETURN         = ret_q;
    assign PREDICTED      = predicted_q;
    assign FLUSH          = (state_q == S_FLUSH);
    assign REDIRECT_VALID = redirect_valid_q;
    assign REDIRECT_ADDR  = redirect_addr_q;
    assign QUEUE_FULL     = (count_q == CW'(DEPTH));
    assign QUEUE_ERR      = queue_err_q;
    assign BRANCH_COUNT   = branch_count_q;
    assign MISPRED_COUNT  = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        CACHE_READY, CACHE_READY_DATA;
    logic        IF_VALID;
    logic [31:0] IF_PRD_ADDR;
    logic        EX_VALID;
    logic [31:0] EX_PC_IN;
    logic        EX_IS_BRANCH, EX_IS_RETURN, EX_TAKEN;
    logic [31:0] EX_TARGET;
    logic        BRANCH, BRANCH_TAKEN, RETURN, PREDICTED, FLUSH;
    logic        REDIRECT_VALID, QUEUE_FULL, QUEUE_ERR;
    logic [31:0] BRANCH_ADDR, EX_PC, REDIRECT_ADDR, BRANCH_COUNT, MISPRED_COUNT;

    int vectors = 0;
    int miscompares = 0;

    branch_resolve_unit #(.ADDR_WIDTH(32), .DEPTH(4), .FLUSH_CYCLES(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CACHE_READY(CACHE_READY), .CACHE_READY_DATA(CACHE_READY_DATA),
        .IF_VALID(IF_VALID), .IF_PRD_ADDR(IF_PRD_ADDR),
        .EX_VALID(EX_VALID), .EX_PC_IN(EX_PC_IN),
        .EX_IS_BRANCH(EX_IS_BRANCH), .EX_IS_RETURN(EX_IS_RETURN),
        .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET),
        .BRANCH(BRANCH), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_ADDR(BRANCH_ADDR),
        .EX_PC(EX_PC), .RETURN(RETURN), .PREDICTED(PREDICTED), .FLUSH(FLUSH),
        .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_ADDR(REDIRECT_ADDR),
        .QUEUE_FULL(QUEUE_FULL), .QUEUE_ERR(QUEUE_ERR),
        .BRANCH_COUNT(BRANCH_COUNT), .MISPRED_COUNT(MISPRED_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive the request, let the edge happen, sample 1ns later, then drop the request
    task automatic cyc(input logic ifv, input logic [31:0] ifa,
                       input logic exv, input logic [31:0] pc,
                       input logic br, input logic ret, input logic tk, input logic [31:0] tgt);
        IF_VALID = ifv; IF_PRD_ADDR = ifa;
        EX_VALID = exv; EX_PC_IN = pc; EX_IS_BRANCH = br; EX_IS_RETURN = ret;
        EX_TAKEN = tk; EX_TARGET = tgt;
        @(posedge CLK);
        #1;
        IF_VALID = 1'b0; EX_VALID = 1'b0; EX_IS_BRANCH = 1'b0; EX_IS_RETURN = 1'b0; EX_TAKEN = 1'b0;
    endtask

    task automatic push(input logic [31:0] a);
        cyc(1'b1, a, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        RST_N = 1'b0; CACHE_READY = 1'b1; CACHE_READY_DATA = 1'b1;
        IF_VALID = 1'b0; IF_PRD_ADDR = '0; EX_VALID = 1'b0; EX_PC_IN = '0;
        EX_IS_BRANCH = 1'b0; EX_IS_RETURN = 1'b0; EX_TAKEN = 1'b0; EX_TARGET = '0;
        @(posedge CLK); #1;
        chk("rst_predicted", PREDICTED, 1);
        chk("rst_flush", FLUSH, 0);
        chk("rst_branch", BRANCH, 0);
        chk("rst_full", QUEUE_FULL, 0);
        chk("rst_err", QUEUE_ERR, 0);
        chk("rst_bcnt", BRANCH_COUNT, 0);
        RST_N = 1'b1;

        // sequential non-branch, correctly predicted
        push(32'h104);
        cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_branch", BRANCH, 0);
        chk("t1_predicted", PREDICTED, 1);
        chk("t1_flush", FLUSH, 0);
        chk("t1_expc", EX_PC, 32'h100);

        // taken branch, correctly predicted
        push(32'h200);
        cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200);
        chk("t2_branch", BRANCH, 1);
        chk("t2_taken", BRANCH_TAKEN, 1);
        chk("t2_baddr", BRANCH_ADDR, 32'h200);
        chk("t2_predicted", PREDICTED, 1);
        chk("t2_bcnt", BRANCH_COUNT, 1);
        chk("t2_mcnt", MISPRED_COUNT, 0);
        idle_cyc();
        chk("t2_nopop_branch", BRANCH, 0);
        chk("t2_nopop_baddr_hold", BRANCH_ADDR, 32'h200);

        // mispredict with a coincident push, then pushes/pops during flush
        push(32'h104); push(32'h108); push(32'h10C);
        cyc(1'b1, 32'h500, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h400);
        chk("t3_predicted", PREDICTED, 0);
        chk("t3_rv", REDIRECT_VALID, 1);
        chk("t3_raddr", REDIRECT_ADDR, 32'h400);
        chk("t3_flush1", FLUSH, 1);
        chk("t3_mcnt", MISPRED_COUNT, 1);
        chk("t3_bcnt", BRANCH_COUNT, 2);
        cyc(1'b1, 32'h600, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_flush2", FLUSH, 1);
        chk("t3_rv_pulse", REDIRECT_VALID, 0);
        chk("t3_pred_back", PREDICTED, 1);
        chk("t3_no_err", QUEUE_ERR, 0);
        idle_cyc();
        chk("t3_flush_end", FLUSH, 0);

        // fill to full, drop a push, push+pop while full, drain in order across the wrap
        push(32'hA0); push(32'hA4); push(32'hA8);
        chk("t4_not_full3", QUEUE_FULL, 0);
        push(32'hAC);
        chk("t4_full", QUEUE_FULL, 1);
        push(32'hB0);
        chk("t4_full_drop", QUEUE_FULL, 1);
        cyc(1'b1, 32'hB4, 1'b1, 32'h9C, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_pp_pred", PREDICTED, 1);
        chk("t4_pp_full", QUEUE_FULL, 1);
        cyc(1'b0, 32'h0, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_pop1_pred", PREDICTED, 1);
        chk("t4_pop1_notfull", QUEUE_FULL, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_pop2_pred", PREDICTED, 1);
        cyc(1'b0, 32'h0, 1'b1, 32'hA8, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_pop3_pred", PREDICTED, 1);
        cyc(1'b0, 32'h0, 1'b1, 32'hAC, 1'b1, 1'b0, 1'b1, 32'hB4);
        chk("t4_pop4_pred", PREDICTED, 1);
        chk("t4_bcnt", BRANCH_COUNT, 3);
        chk("t4_mcnt", MISPRED_COUNT, 1);

        // mispredicting return, flush frozen by data-cache stall
        push(32'h304);
        cyc(1'b0, 32'h0, 1'b1, 32'h2FC, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("t5_predicted", PREDICTED, 0);
        chk("t5_return", RETURN, 1);
        chk("t5_raddr", REDIRECT_ADDR, 32'h300);
        chk("t5_mcnt", MISPRED_COUNT, 2);
        chk("t5_bcnt", BRANCH_COUNT, 3);
        CACHE_READY_DATA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h900, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("t5_frozen_flush", FLUSH, 1);
            chk("t5_frozen_rv", REDIRECT_VALID, 1);
            chk("t5_frozen_pred", PREDICTED, 0);
        end
        CACHE_READY_DATA = 1'b1;
        idle_cyc();
        chk("t5_flush2", FLUSH, 1);
        chk("t5_rv_drop", REDIRECT_VALID, 0);
        idle_cyc();
        chk("t5_flush_end", FLUSH, 0);
        chk("t5_err_clear", QUEUE_ERR, 0);
        cyc(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("t5_err_set", QUEUE_ERR, 1);
        chk("t5_err_nofb", BRANCH, 0);
        chk("t5_err_bcnt", BRANCH_COUNT, 3);
        idle_cyc();
        chk("t5_err_sticky", QUEUE_ERR, 1);

        // async reset in the middle of a flush
        push(32'h700);
        cyc(1'b0, 32'h0, 1'b1, 32'h600, 1'b1, 1'b0, 1'b1, 32'h800);
        chk("t6_mcnt", MISPRED_COUNT, 3);
        chk("t6_bcnt", BRANCH_COUNT, 4);
        idle_cyc();
        chk("t6_flush2", FLUSH, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("t6_flush", FLUSH, 0);
        chk("t6_pred", PREDICTED, 1);
        chk("t6_bcnt0", BRANCH_COUNT, 0);
        chk("t6_mcnt0", MISPRED_COUNT, 0);
        chk("t6_err0", QUEUE_ERR, 0);
        chk("t6_raddr0", REDIRECT_ADDR, 0);
        RST_N = 1'b1;
        idle_cyc();
        chk("t6_after_flush", FLUSH, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
